axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ARSIZE_VAL, 3'b011, fixed ARSIZE driven on every request (8-byte beat).
- ARPROT_IFU, 3'b100, ARPORT value for port 0 (instruction access).
- ARPROT_LSU, 3'b000, ARPORT value for port 1 (data access).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, all state on posedge.
- rstn  in  1  reset, asynchronous and active-low.
- m0_req  in  1  IFU read request; held until m0_gnt.
- m0_addr  in  64  IFU read address; stable while m0_req.
- m0_flush  in  1  IFU abort; drops IFU read in flight.
- m0_gnt  out  1  IFU request accepted this cycle.
- m0_rvalid  out  1  IFU response pulse, 1 cycle.
- m0_rdata  out  64  IFU read data.
- m0_rresp  out  2  IFU response code.
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata, m1_rresp  same widths  LSU port, same meaning, no flush input.
- ARID  out  4  granted port index (4'd0 or 4'd1).
- ARADDR  out  64  latched address.
- ARLEN  out  8  constant 8'd0 (single beat).
- ARSIZE  out  3  ARSIZE_VAL.
- ARBURST  out  2  constant 2'b01.
- ARPORT  out  3  ARPROT_IFU or ARPROT_LSU per owner.
- ARVALID  out  1  AR valid.
- ARREADY  in  1  AR ready.
- RDATA  in  64  read data.
- RRESP  in  2  read response.
- RVALID  in  1  R valid.
- RREADY  out  1  R ready.

Function
REQ-003 FSM states: IDLE, ADDR, DATA, RESP; one outstanding transaction maximum.
REQ-004 IDLE: eligible requesters are m1_req and (m0_req and not m0_flush); if any is eligible, grant one, assert its gnt combinationally in the same cycle, latch addr/owner, go to ADDR.
REQ-005 Arbitration is round-robin on a last_owner flag: on a tie, grant the port not granted last; a single eligible requester always wins.
REQ-006 gnt is asserted only in IDLE; the two gnt outputs are never high together.
REQ-007 ADDR: ARVALID=1; ARADDR, ARID, ARPORT, ARLEN, ARSIZE and ARBURST stay stable until ARREADY; on ARVALID and ARREADY go to DATA.
REQ-008 DATA: RREADY=1; on RVALID, register RDATA/RRESP into the owner's rdata/rresp, then go to RESP.
REQ-009 RESP: the owner's rvalid=1 for exactly one cycle unless dropped; go to IDLE next cycle; rdata/rresp hold until the next response.
REQ-010 Best-case latency: req at cycle 0 (gnt 0); ARVALID at cycle 1; with ARREADY at 1 and RVALID at 2, rvalid is at cycle 3; next gnt is possible in cycle 4.
REQ-011 Abort: m0_flush high in any cycle while owner=0 in ADDR, DATA or RESP sets the drop flag, including a flush coincident with RVALID or in RESP itself.
- The AR handshake still completes (ARVALID is never retracted) and the R beat is still accepted.
- With drop set, m0_rvalid stays 0 and m0_rdata/m0_rresp are not updated.
- The drop flag clears on entry to IDLE.
REQ-012 m0_flush while owner=1 has no effect on the transaction.
REQ-013 RRESP is passed through unmodified, including SLVERR/DECERR; the arbiter does not retry.
REQ-014 Requests arriving in ADDR, DATA or RESP wait without gnt; no request is lost while req is held.

Reset
REQ-015 rstn low asynchronously forces: state=IDLE, ARVALID=0, RREADY=0, m0_rvalid=m1_rvalid=0, rdata=64'd0, rresp=2'd0, ARADDR=64'd0, ARID=4'd0, last_owner=1 (port 0 wins the first tie), drop=0.
REQ-016 m0_gnt and m1_gnt are 0 while rstn is low.
REQ-017 Reset mid-transaction abandons it: no rvalid is produced afterwards; the bench must not return the orphaned R beat.

Verification
REQ-018 The bench shall cover:
- Single IFU read: m0_req, addr 0x8000_0000, ARREADY immediate, RVALID one cycle later with RDATA 0x0000_0013_0000_0093 → ARID=0, ARPORT=3'b100, m0_rvalid at cycle 3 with that data, rresp=0.
- Simultaneous m0_req and m1_req from reset → port 0 granted first, then port 1 (ARID=1, ARPORT=0); repeat tie → order alternates 0,1,0,1.
- ARREADY withheld 5 cycles → ARVALID and ARADDR stable for all 5 cycles, one AR handshake total.
- m0_flush during DATA, RVALID 3 cycles later → RREADY accepts the beat, m0_rvalid never asserts, m0_rdata unchanged, next m1_req granted in IDLE.
- m0_req with m0_flush in IDLE alongside m1_req → only m1_gnt asserts.
- rstn pulsed low in DATA → ARVALID, RREADY and all rvalid are 0 immediately; after release a fresh m1 read completes normally with RRESP=2'b10 forwarded to m1_rresp.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-port (IFU/LSU) round-robin read arbiter onto one AXI AR/R channel, one read outstanding.
// Grant in the request cycle, rvalid three cycles later best case; the R beat is always accepted, even for a dropped IFU read.
module axi_rd_arbiter #(
   parameter logic [2:0] ARSIZE_VAL = 3'b011,
   parameter logic [2:0] ARPROT_IFU = 3'b100,
   parameter logic [2:0] ARPROT_LSU = 3'b000
) (
   input  logic        clk,
   input  logic        rstn,

   input  logic        m0_req,
   input  logic [63:0] m0_addr,
   input  logic        m0_flush,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [63:0] m0_rdata,
   output logic [1:0]  m0_rresp,

   input  logic        m1_req,
   input  logic [63:0] m1_addr,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [63:0] m1_rdata,
   output logic [1:0]  m1_rresp,

   output logic [3:0]  ARID,
   output logic [63:0] ARADDR,
   output logic [7:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic [2:0]  ARPORT,
   output logic        ARVALID,
   input  logic        ARREADY,

   input  logic [63:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RVALID,
   output logic        RREADY
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic        owner;
   logic        last_owner;
   logic        drop;
   logic [63:0] addr_q;

   logic        elig0;
   logic        elig1;
   logic        pick1;
   logic        grant;
   logic        ar_fire;
   logic        r_fire;
   logic        flush_hit;

   logic [63:0] rdata0;
   logic [63:0] rdata1;
   logic [1:0]  rresp0;
   logic [1:0]  rresp1;

   // An IFU request that is being flushed in the same cycle is not eligible.
   assign elig0 = m0_req & ~m0_flush;
   assign elig1 = m1_req;

   // On a tie, the port that did not win last time is picked.
   assign pick1 = elig1 & (~elig0 | ~last_owner);
   assign grant = rstn & (state == IDLE) & (elig0 | elig1);

   assign m0_gnt = grant & ~pick1;
   assign m1_gnt = grant & pick1;

   assign ar_fire   = (state == ADDR) & ARREADY;
   assign r_fire    = (state == DATA) & RVALID;
   assign flush_hit = (state != IDLE) & ~owner & m0_flush;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant)   state_nxt = ADDR;
         ADDR:    if (ar_fire) state_nxt = DATA;
         DATA:    if (r_fire)  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         drop       <= 1'b0;
         addr_q     <= 64'd0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            owner      <= pick1;
            last_owner <= pick1;
            addr_q     <= pick1 ? m1_addr : m0_addr;
         end
         // RESP always returns to IDLE, so clearing here clears on IDLE entry.
         if (state == RESP)
            drop <= 1'b0;
         else if (flush_hit)
            drop <= 1'b1;
      end
   end

   // A flush coincident with the R beat must also keep the IFU data untouched.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata0 <= 64'd0;
         rresp0 <= 2'd0;
         rdata1 <= 64'd0;
         rresp1 <= 2'd0;
      end else if (r_fire) begin
         if (owner) begin
            rdata1 <= RDATA;
            rresp1 <= RRESP;
         end else if (!drop && !flush_hit) begin
            rdata0 <= RDATA;
            rresp0 <= RRESP;
         end
      end
   end

   assign m0_rvalid = (state == RESP) & ~owner & ~drop & ~m0_flush;
   assign m1_rvalid = (state == RESP) & owner;
   assign m0_rdata  = rdata0;
   assign m0_rresp  = rresp0;
   assign m1_rdata  = rdata1;
   assign m1_rresp  = rresp1;

   assign ARVALID = (state == ADDR);
   assign ARID    = {3'b000, owner};
   assign ARADDR  = addr_q;
   assign ARPORT  = owner ? ARPROT_LSU : ARPROT_IFU;
   assign ARLEN   = 8'd0;
   assign ARSIZE  = ARSIZE_VAL;
   assign ARBURST = 2'b01;
   assign RREADY  = (state == DATA);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed reads, a reactive AXI slave, and AR/R monitors.
module tb_axi_rd_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        m0_req, m0_flush, m0_gnt, m0_rvalid;
   logic [63:0] m0_addr, m0_rdata;
   logic [1:0]  m0_rresp;
   logic        m1_req, m1_gnt, m1_rvalid;
   logic [63:0] m1_addr, m1_rdata;
   logic [1:0]  m1_rresp;
   logic [3:0]  ARID;
   logic [63:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic [2:0]  ARPORT;
   logic        ARVALID, ARREADY;
   logic [63:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID, RREADY;

   always #5 clk = ~clk;

   axi_rd_arbiter dut (
      .clk(clk), .rstn(rstn),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_flush(m0_flush), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARPORT(ARPORT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   typedef struct { logic [3:0] id; logic [63:0] addr; logic [2:0] prot; } ar_exp_t;
   typedef struct { int port; logic [63:0] data; logic [1:0] resp; int cyc; } rsp_exp_t;
   typedef struct { logic [63:0] data; logic [1:0] resp; } beat_t;

   ar_exp_t  ar_q[$];
   rsp_exp_t rsp_q[$];
   beat_t    slv_q[$];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int ar_wait = 0;
   int r_wait = 0;
   int ar_hs = 0;
   int ar_stall = 0;
   int r_hs = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_read(input int p, input logic [63:0] a, input logic [63:0] d,
                            input logic [1:0] r, input int ecyc, input bit deliver);
      ar_exp_t ea;
      rsp_exp_t er;
      beat_t b;
      ea.id = 4'(p); ea.addr = a; ea.prot = (p == 0) ? 3'b100 : 3'b000;
      ar_q.push_back(ea);
      b.data = d; b.resp = r;
      slv_q.push_back(b);
      if (deliver) begin
         er.port = p; er.data = d; er.resp = r; er.cyc = ecyc;
         rsp_q.push_back(er);
      end
   endtask

   // Call at posedge+1; returns at posedge+1 of the cycle after the grant.
   task automatic issue(input int p, input logic [63:0] a, output int gcyc);
      gcyc = -1;
      if (p == 0) begin m0_req = 1'b1; m0_addr = a; end
      else begin m1_req = 1'b1; m1_addr = a; end
      for (int n = 0; n < 200 && gcyc < 0; n++) begin
         @(negedge clk);
         if ((p == 0) ? m0_gnt : m1_gnt) gcyc = cyc;
         @(posedge clk); #1;
      end
      if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
      if (gcyc < 0) begin
         vectors++; miscompares++;
         $display("FAIL gnt_timeout: port %0d got no grant within 200 cycles", p);
      end
   endtask

   task automatic drain();
      int n;
      for (n = 0; n < 300 && (rsp_q.size() != 0 || ar_q.size() != 0 || slv_q.size() != 0); n++) begin
         @(posedge clk); #1;
      end
      if (n >= 300) begin
         vectors++; miscompares++;
         $display("FAIL drain_timeout: ar=%0d rsp=%0d beats=%0d still pending, expected 0",
                  ar_q.size(), rsp_q.size(), slv_q.size());
      end
      repeat (3) begin @(posedge clk); #1; end
   endtask

   // Reactive AXI slave: ARREADY after ar_wait stall cycles, RVALID after r_wait DATA cycles.
   initial begin : slave
      int ph;
      int cnt;
      beat_t b;
      ph = 0; cnt = 0;
      ARREADY = 1'b0; RVALID = 1'b0; RDATA = 64'd0; RRESP = 2'd0;
      forever begin
         @(posedge clk); #1;
         if (!rstn) begin
            ph = 0; cnt = 0; ARREADY = 1'b0; RVALID = 1'b0; slv_q.delete();
         end else begin
            if (ph == 3) begin RVALID = 1'b0; ph = 0; cnt = 0; end
            if (ph == 1) begin ARREADY = 1'b0; ph = 2; cnt = 0; end
            if (ph == 2) begin
               if (cnt >= r_wait) begin
                  b.data = 64'd0; b.resp = 2'd0;
                  if (slv_q.size() > 0) b = slv_q.pop_front();
                  RDATA = b.data; RRESP = b.resp; RVALID = 1'b1; ph = 3;
               end else cnt++;
            end
            if (ph == 0 && ARVALID) begin
               if (cnt >= ar_wait) begin ARREADY = 1'b1; ph = 1; end
               else cnt++;
            end
         end
      end
   end

   ar_exp_t     ea_m;
   rsp_exp_t    er_m;
   logic        prev_av = 1'b0;
   logic        prev_hs = 1'b0;
   logic [63:0] prev_addr;
   logic [3:0]  prev_id;
   logic [2:0]  prev_prot;

   always @(negedge clk) begin
      check("gnt_onehot", 64'(m0_gnt & m1_gnt), 64'd0);
      if (ARVALID && ARREADY) begin
         ar_hs++;
         if (ar_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL ar_unexpected: handshake addr 0x%0h, expected none", ARADDR);
         end else begin
            ea_m = ar_q.pop_front();
            check("ar_id", 64'(ARID), 64'(ea_m.id));
            check("ar_addr", ARADDR, ea_m.addr);
            check("ar_prot", 64'(ARPORT), 64'(ea_m.prot));
            check("ar_len", 64'(ARLEN), 64'd0);
            check("ar_size", 64'(ARSIZE), 64'd3);
            check("ar_burst", 64'(ARBURST), 64'd1);
         end
      end
      if (ARVALID && !ARREADY) ar_stall++;
      if (!rstn) prev_av = 1'b0;
      else begin
         if (ARVALID && prev_av && !prev_hs) begin
            check("ar_addr_stable", ARADDR, prev_addr);
            check("ar_id_stable", 64'(ARID), 64'(prev_id));
            check("ar_prot_stable", 64'(ARPORT), 64'(prev_prot));
         end
         prev_av = ARVALID; prev_hs = ARVALID && ARREADY;
         prev_addr = ARADDR; prev_id = ARID; prev_prot = ARPORT;
      end
      if (RVALID && RREADY) r_hs++;
      if (m0_rvalid || m1_rvalid) begin
         check("rvalid_onehot", 64'(m0_rvalid & m1_rvalid), 64'd0);
         if (rsp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL rvalid_unexpected: m0_rvalid=%0b m1_rvalid=%0b, expected none", m0_rvalid, m1_rvalid);
         end else begin
            er_m = rsp_q.pop_front();
            check("rsp_port", 64'(m1_rvalid), 64'(er_m.port));
            check("rsp_data", (er_m.port == 1) ? m1_rdata : m0_rdata, er_m.data);
            check("rsp_resp", 64'((er_m.port == 1) ? m1_rresp : m0_rresp), 64'(er_m.resp));
            if (er_m.cyc >= 0) check("rsp_cycle", 64'(cyc), 64'(er_m.cyc));
         end
      end
   end

   initial begin : watchdog
      #200000;
      vectors++; miscompares++;
      $display("FAIL watchdog: stimulus incomplete at cycle %0d, expected to finish", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : main
      int g0, g1, c0, s0, h0, r0;
      rstn = 1'b0; m0_req = 1'b0; m0_addr = 64'd0; m0_flush = 1'b0;
      m1_req = 1'b0; m1_addr = 64'd0;
      repeat (2) @(posedge clk);
      #1; m0_req = 1'b1; m1_req = 1'b1;
      @(negedge clk);
      check("rst_m0_gnt", 64'(m0_gnt), 64'd0);
      check("rst_m1_gnt", 64'(m1_gnt), 64'd0);
      check("rst_arvalid", 64'(ARVALID), 64'd0);
      check("rst_rready", 64'(RREADY), 64'd0);
      check("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
      check("rst_m1_rvalid", 64'(m1_rvalid), 64'd0);
      check("rst_m0_rdata", m0_rdata, 64'd0);
      check("rst_m1_rdata", m1_rdata, 64'd0);
      check("rst_m0_rresp", 64'(m0_rresp), 64'd0);
      check("rst_m1_rresp", 64'(m1_rresp), 64'd0);
      check("rst_araddr", ARADDR, 64'd0);
      check("rst_arid", 64'(ARID), 64'd0);
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = 1'b0; rstn = 1'b1;
      @(posedge clk); #1;

      // Tie from reset: port 0 first, then port 1; a second tie repeats the order.
      push_read(0, 64'h1000, 64'h1111_2222_3333_4444, 2'b00, -1, 1'b1);
      push_read(1, 64'h2000, 64'h5555_6666_7777_8888, 2'b01, -1, 1'b1);
      fork
         issue(0, 64'h1000, g0);
         issue(1, 64'h2000, g1);
      join
      check("tie1_m1_after_m0", 64'(g1 - g0), 64'd4);
      drain();
      push_read(0, 64'h1008, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00, -1, 1'b1);
      push_read(1, 64'h2008, 64'h5A5A_5A5A_5A5A_5A5A, 2'b00, -1, 1'b1);
      fork
         issue(0, 64'h1008, g0);
         issue(1, 64'h2008, g1);
      join
      check("tie2_m1_after_m0", 64'(g1 - g0), 64'd4);
      drain();

      // Single IFU read at best-case latency, LSU request queued behind it.
      c0 = cyc;
      push_read(0, 64'h8000_0000, 64'h0000_0013_0000_0093, 2'b00, c0 + 3, 1'b1);
      push_read(1, 64'h2010, 64'h0123_4567_89AB_CDEF, 2'b00, c0 + 7, 1'b1);
      fork
         issue(0, 64'h8000_0000, g0);
         begin
            @(posedge clk); #1;
            issue(1, 64'h2010, g1);
         end
      join
      check("ifu_gnt_cycle", 64'(g0), 64'(c0));
      check("next_gnt_cycle", 64'(g1), 64'(c0 + 4));
      drain();

      // ARREADY withheld 5 cycles.
      ar_wait = 5;
      s0 = ar_stall; h0 = ar_hs;
      push_read(0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hCAFE_F00D_0000_0001, 2'b00, -1, 1'b1);
      issue(0, 64'hFFFF_FFFF_FFFF_FFF8, g0);
      drain();
      check("ar_stall_cycles", 64'(ar_stall - s0), 64'd5);
      check("ar_handshakes", 64'(ar_hs - h0), 64'd1);
      ar_wait = 0;

      // Port 0 won last, so this tie goes to port 1 first; DECERR forwarded to IFU.
      push_read(1, 64'h3000, 64'h0000_0000_0000_0001, 2'b00, -1, 1'b1);
      push_read(0, 64'h4000, 64'hDEC0_DE00_0000_0003, 2'b11, -1, 1'b1);
      fork
         issue(0, 64'h4000, g0);
         issue(1, 64'h3000, g1);
      join
      check("tie3_m0_after_m1", 64'(g0 - g1), 64'd4);
      drain();

      // Flush during DATA: beat accepted, no m0_rvalid, m0 data kept.
      r_wait = 3;
      r0 = r_hs;
      push_read(0, 64'h5000, 64'hBAD0_BAD0_BAD0_BAD0, 2'b00, -1, 1'b0);
      issue(0, 64'h5000, g0);
      @(posedge clk); #1;
      check("flush_in_data_rready", 64'(RREADY), 64'd1);
      m0_flush = 1'b1;
      @(posedge clk); #1;
      m0_flush = 1'b0;
      drain();
      r_wait = 0;
      check("flush_beat_accepted", 64'(r_hs - r0), 64'd1);
      check("flush_m0_rdata_kept", m0_rdata, 64'hDEC0_DE00_0000_0003);
      check("flush_m0_rresp_kept", 64'(m0_rresp), 64'd3);
      push_read(1, 64'h6000, 64'h6666_6666_6666_6666, 2'b00, -1, 1'b1);
      issue(1, 64'h6000, g1);
      drain();

      // Flushed m0_req alongside m1_req in IDLE; flush held through the LSU read.
      push_read(1, 64'h7000, 64'h7777_0000_7777_0000, 2'b00, -1, 1'b1);
      m0_req = 1'b1; m0_addr = 64'h9000; m0_flush = 1'b1;
      m1_req = 1'b1; m1_addr = 64'h7000;
      @(negedge clk);
      check("flush_idle_m0_gnt", 64'(m0_gnt), 64'd0);
      check("flush_idle_m1_gnt", 64'(m1_gnt), 64'd1);
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = 1'b0;
      drain();
      m0_flush = 1'b0;

      // Reset in DATA: everything idles at once; the orphan beat is never returned.
      r_wait = 10;
      push_read(1, 64'hA000, 64'h0000_0000_0000_0BAD, 2'b00, -1, 1'b0);
      issue(1, 64'hA000, g1);
      @(posedge clk); #1;
      check("pre_reset_rready", 64'(RREADY), 64'd1);
      m1_req = 1'b1; m1_addr = 64'hB000;
      rstn = 1'b0;
      #1;
      check("mid_rst_arvalid", 64'(ARVALID), 64'd0);
      check("mid_rst_rready", 64'(RREADY), 64'd0);
      check("mid_rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
      check("mid_rst_m1_rvalid", 64'(m1_rvalid), 64'd0);
      check("mid_rst_m1_gnt", 64'(m1_gnt), 64'd0);
      check("mid_rst_m1_rdata", m1_rdata, 64'd0);
      repeat (2) begin @(posedge clk); #1; end
      m1_req = 1'b0; r_wait = 0;
      slv_q.delete();
      rstn = 1'b1;
      @(posedge clk); #1;
      push_read(1, 64'hB000, 64'h0B0B_0B0B_0B0B_0B0B, 2'b10, -1, 1'b1);
      issue(1, 64'hB000, g1);
      drain();

      check("end_ar_queue", 64'(ar_q.size()), 64'd0);
      check("end_rsp_queue", 64'(rsp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
